// File: rtl/gray_decoder.sv
// gray_decoder: gray-to-binary receiver that checks each sample is a legal single-step increment,
// pulses on wrap, counts wraps (saturating) and latches a sticky error on any illegal step.
module gray_decoder #(
   parameter int WIDTH     = 3,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid,
   input  logic [WIDTH-1:0]     gray,
   input  logic                 clear,
   output logic [WIDTH-1:0]     binary,
   output logic                 wrap,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] wrap_cnt
);
   typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;
   state_t state;
   logic [WIDTH-1:0] last, dec;
   logic same, step, at_max, cnt_full;
   // each binary bit is the parity of the gray bits at and above it
   for (genvar i = 0; i < WIDTH; i++) begin : g_dec
      assign dec[i] = ^(gray >> i);
   end
   always_comb begin
      same     = gray == last;
      step     = dec == binary + WIDTH'(1);
      at_max   = &binary;
      cnt_full = &wrap_cnt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         binary   <= '0;
         last     <= '0;
         wrap     <= 1'b0;
         error    <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         wrap <= 1'b0;
         if (clear) begin
            error    <= 1'b0;
            wrap_cnt <= '0;
            state    <= valid ? TRACK : IDLE;
         end
         if (valid) begin
            binary <= dec;
            last   <= gray;
         end
         if (valid && !clear)
            case (state)
               IDLE: state <= TRACK;
               TRACK:
                  if (!same) begin
                     if (step) begin
                        wrap <= at_max;
                        if (at_max && !cnt_full) wrap_cnt <= wrap_cnt + CNT_WIDTH'(1);
                     end else begin
                        error <= 1'b1;
                        state <= ERR;
                     end
                  end
               default: ;
            endcase
      end
   end
endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: directed vectors with hand-computed expectations queued per cycle and
// checked by an independent monitor; a second instance covers wrap-count saturation.
module tb_gray_decoder;
   logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clear = 1'b0;
   logic [2:0] gray = '0;
   logic [2:0] b0, b1;
   logic w0, w1, e0, e1;
   logic [7:0] c0;
   logic [1:0] c1;
   int compared = 0, mismatched = 0;

   typedef struct {
      logic [2:0] b;
      logic       w;
      logic       e;
      logic [7:0] c;
      logic [1:0] c2;
   } exp_t;
   exp_t q[$];
   logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

   gray_decoder u0 (.clk(clk), .rst_n(rst_n), .valid(valid), .gray(gray), .clear(clear),
                    .binary(b0), .wrap(w0), .error(e0), .wrap_cnt(c0));
   gray_decoder #(.WIDTH(3), .CNT_WIDTH(2)) u1 (.clk(clk), .rst_n(rst_n), .valid(valid), .gray(gray),
                    .clear(clear), .binary(b1), .wrap(w1), .error(e1), .wrap_cnt(c1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic c, input logic [2:0] g,
                       input logic [2:0] eb, input logic ew, input logic ee, input logic [7:0] ec);
      exp_t x;
      @(negedge clk);
      valid = v; clear = c; gray = g;
      x.b = eb; x.w = ew; x.e = ee; x.c = ec; x.c2 = (ec > 8'd3) ? 2'd3 : ec[1:0];
      q.push_back(x);
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("binary", b0, x.b);
            chk("wrap", w0, x.w);
            chk("error", e0, x.e);
            chk("wrap_cnt", c0, x.c);
            chk("sat_wrap", w1, x.w);
            chk("sat_binary", b1, x.b);
            chk("sat_wrap_cnt", c1, x.c2);
         end
      end
   end

   initial begin
      #12;
      chk("rst_binary", b0, 0);
      chk("rst_wrap", w0, 0);
      chk("rst_error", e0, 0);
      chk("rst_wrap_cnt", c0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // full count sequence with wrap
      for (int k = 0; k < 8; k++) step(1, 0, seq[k], 3'(k), 0, 0, 0);
      step(1, 0, 3'b000, 0, 1, 0, 1);
      // repeats and idle cycles
      for (int k = 0; k < 5; k++) step(1, 0, 3'b001, 1, 0, 0, 1);
      for (int k = 0; k < 3; k++) step(0, 0, 3'b111, 1, 0, 0, 1);
      // skip into ERR, then no checks or wraps
      step(1, 0, 3'b011, 2, 0, 0, 1);
      step(1, 0, 3'b110, 4, 0, 1, 1);
      step(1, 0, 3'b111, 5, 0, 1, 1);
      step(1, 0, 3'b100, 7, 0, 1, 1);
      step(1, 0, 3'b000, 0, 0, 1, 1);
      // clear with sample, back step, clear again
      step(1, 1, 3'b001, 1, 0, 0, 0);
      step(1, 0, 3'b011, 2, 0, 0, 0);
      step(1, 0, 3'b010, 3, 0, 0, 0);
      step(1, 0, 3'b011, 2, 0, 1, 0);
      step(1, 1, 3'b001, 1, 0, 0, 0);
      step(1, 0, 3'b011, 2, 0, 0, 0);
      // clear without sample: next sample is unchecked
      step(0, 1, 3'b110, 2, 0, 0, 0);
      step(1, 0, 3'b110, 4, 0, 0, 0);
      step(1, 0, 3'b111, 5, 0, 0, 0);
      step(1, 0, 3'b000, 0, 0, 1, 0);
      step(0, 1, 3'b000, 0, 0, 0, 0);
      // saturation: five full cycles
      step(1, 1, 3'b000, 0, 0, 0, 0);
      for (int r = 1; r <= 5; r++) begin
         for (int k = 1; k < 8; k++) step(1, 0, seq[k], 3'(k), 0, 0, 8'(r - 1));
         step(1, 0, 3'b000, 0, 1, 0, 8'(r));
         if (r == 1) step(1, 0, 3'b000, 0, 0, 0, 1);
      end
      // mid-sequence async reset
      for (int k = 1; k < 7; k++) step(1, 0, seq[k], 3'(k), 0, 0, 5);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      valid = 1'b0;
      #1;
      chk("async_binary", b0, 0);
      chk("async_error", e0, 0);
      chk("async_wrap_cnt", c0, 0);
      chk("async_sat_cnt", c1, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 3'b101, 6, 0, 0, 0);
      step(1, 0, 3'b100, 7, 0, 0, 0);
      step(1, 0, 3'b000, 0, 1, 0, 1);
      step(1, 0, 3'b000, 0, 0, 0, 1);
      step(1, 0, 3'b101, 6, 0, 1, 1);
      step(0, 0, 3'b000, 6, 0, 1, 1);
      for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
